// File: rtl/noc_axi4_resp_sched.sv
// noc_axi4_resp_sched: merges the read-data and write-ack response streams onto
// the single serializer input of the NoC-AXI4 bridge. Round-robin by default;
// with RDWR_INORDER=1 responses leave strictly in request issue order, tracked
// by a 1-bit-wide order FIFO (0 = read, 1 = write). One registered output stage.

`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 64
`endif

module noc_axi4_resp_sched #(
    parameter int ID_WIDTH         = `AXI4_ID_WIDTH,
    parameter int DATA_WIDTH       = `AXI4_DATA_WIDTH,
    parameter int RDWR_INORDER     = 0,
    parameter int ORDER_DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_issue_val,
    input  logic                  wr_issue_val,
    output logic                  issue_rdy,
    input  logic                  rd_resp_val,
    input  logic [ID_WIDTH-1:0]   rd_resp_id,
    input  logic [DATA_WIDTH-1:0] rd_resp_data,
    output logic                  rd_resp_rdy,
    input  logic                  wr_resp_val,
    input  logic [ID_WIDTH-1:0]   wr_resp_id,
    output logic                  wr_resp_rdy,
    output logic                  out_val,
    output logic                  out_is_wr,
    output logic [ID_WIDTH-1:0]   out_id,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_rdy,
    output logic                  order_err
);

    localparam int  AW       = ORDER_DEPTH_LOG2;
    localparam int  PTR_W    = ORDER_DEPTH_LOG2 + 1;
    localparam int  DEPTH    = 1 << ORDER_DEPTH_LOG2;
    localparam bit  IN_ORDER = (RDWR_INORDER != 0);

    // Order FIFO state; pointers carry one extra wrap bit so full and empty differ.
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    fifo_cnt;
    logic [PTR_W-1:0]    free_cnt;
    logic                fifo_mem [DEPTH];
    logic                fifo_empty;
    logic                fifo_head;
    logic                issue_ok;
    logic                issue_bad;
    logic                push_rd;
    logic                push_wr;
    logic                pop;
    logic [AW-1:0]       wr_idx0;
    logic [AW-1:0]       wr_idx1;

    // Arbitration and output stage
    logic                load_en;
    logic                grant_rd;
    logic                grant_wr;
    logic                resp_err;
    logic                last_wr;
    logic                err_q;
    logic                vld_p1;
    logic                is_wr_p1;
    logic [ID_WIDTH-1:0] id_p1;
    logic [DATA_WIDTH-1:0] data_p1;

    // Order FIFO occupancy, head, and push qualification (a blocked issue drops all its pushes).
    always_comb begin
        fifo_cnt   = wr_ptr - rd_ptr;
        free_cnt   = PTR_W'(DEPTH) - fifo_cnt;
        fifo_empty = (fifo_cnt == '0);
        fifo_head  = fifo_mem[rd_ptr[AW-1:0]];
        issue_ok   = (free_cnt >= PTR_W'(2));
        issue_bad  = IN_ORDER && rst_n && (rd_issue_val || wr_issue_val) && !issue_ok;
        push_rd    = IN_ORDER && rst_n && rd_issue_val && issue_ok;
        push_wr    = IN_ORDER && rst_n && wr_issue_val && issue_ok;
        wr_idx0    = wr_ptr[AW-1:0];
        wr_idx1    = wr_idx0 + AW'(1);
    end

    // Winner selection: only while the output register can load; in-order follows the FIFO head.
    always_comb begin
        load_en  = !vld_p1 || out_rdy;
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (rst_n && load_en) begin
            if (IN_ORDER) begin
                if (!fifo_empty) begin
                    grant_rd = !fifo_head && rd_resp_val;
                    grant_wr = fifo_head && wr_resp_val;
                end
            end else if (rd_resp_val && wr_resp_val) begin
                grant_wr = !last_wr;
                grant_rd = last_wr;
            end else begin
                grant_rd = rd_resp_val;
                grant_wr = wr_resp_val;
            end
        end
        pop      = IN_ORDER && (grant_rd || grant_wr);
        resp_err = IN_ORDER && rst_n && fifo_empty && (rd_resp_val || wr_resp_val);
    end

    // Control state: FIFO pointers, round-robin history and the sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            last_wr <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            wr_ptr <= wr_ptr + PTR_W'(push_rd) + PTR_W'(push_wr);
            if (grant_rd || grant_wr)
                last_wr <= grant_wr;
            if (issue_bad || resp_err)
                err_q <= 1'b1;
        end
    end

    // FIFO storage: a simultaneous read+write issue records read first, then write.
    always_ff @(posedge clk) begin
        if (push_rd)
            fifo_mem[wr_idx0] <= 1'b0;
        if (push_wr)
            fifo_mem[push_rd ? wr_idx1 : wr_idx0] <= 1'b1;
    end

    // ---- stage p1: registered output toward the serializer ----
    // Output register loads the winner whenever it is empty or being drained.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            is_wr_p1 <= 1'b0;
            id_p1    <= '0;
            data_p1  <= '0;
        end else if (load_en) begin
            vld_p1 <= grant_rd || grant_wr;
            if (grant_rd || grant_wr) begin
                is_wr_p1 <= grant_wr;
                id_p1    <= grant_wr ? wr_resp_id : rd_resp_id;
                data_p1  <= grant_wr ? '0 : rd_resp_data;
            end
        end
    end

    assign rd_resp_rdy = grant_rd;
    assign wr_resp_rdy = grant_wr;
    assign issue_rdy   = rst_n && (!IN_ORDER || issue_ok);
    assign out_val     = vld_p1;
    assign out_is_wr   = is_wr_p1;
    assign out_id      = id_p1;
    assign out_data    = data_p1;
    assign order_err   = err_q;

endmodule

// File: tb/tb_noc_axi4_resp_sched.sv
// Bench for noc_axi4_resp_sched: one round-robin instance and one in-order
// instance (order FIFO depth 4). Vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.

module tb_noc_axi4_resp_sched;

    localparam int IW = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Round-robin instance signals
    logic          r_rd_issue, r_wr_issue, r_issue_rdy;
    logic          r_rd_val, r_rd_rdy, r_wr_val, r_wr_rdy;
    logic [IW-1:0] r_rd_id, r_wr_id, r_out_id;
    logic [DW-1:0] r_rd_data, r_out_data;
    logic          r_out_val, r_out_is_wr, r_out_rdy, r_err;

    // In-order instance signals
    logic          q_rd_issue, q_wr_issue, q_issue_rdy;
    logic          q_rd_val, q_rd_rdy, q_wr_val, q_wr_rdy;
    logic [IW-1:0] q_rd_id, q_wr_id, q_out_id;
    logic [DW-1:0] q_rd_data, q_out_data;
    logic          q_out_val, q_out_is_wr, q_out_rdy, q_err;

    noc_axi4_resp_sched #(.ID_WIDTH(IW), .DATA_WIDTH(DW), .RDWR_INORDER(0), .ORDER_DEPTH_LOG2(2)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .rd_issue_val(r_rd_issue), .wr_issue_val(r_wr_issue), .issue_rdy(r_issue_rdy),
        .rd_resp_val(r_rd_val), .rd_resp_id(r_rd_id), .rd_resp_data(r_rd_data), .rd_resp_rdy(r_rd_rdy),
        .wr_resp_val(r_wr_val), .wr_resp_id(r_wr_id), .wr_resp_rdy(r_wr_rdy),
        .out_val(r_out_val), .out_is_wr(r_out_is_wr), .out_id(r_out_id), .out_data(r_out_data),
        .out_rdy(r_out_rdy), .order_err(r_err)
    );

    noc_axi4_resp_sched #(.ID_WIDTH(IW), .DATA_WIDTH(DW), .RDWR_INORDER(1), .ORDER_DEPTH_LOG2(2)) u_io (
        .clk(clk), .rst_n(rst_n),
        .rd_issue_val(q_rd_issue), .wr_issue_val(q_wr_issue), .issue_rdy(q_issue_rdy),
        .rd_resp_val(q_rd_val), .rd_resp_id(q_rd_id), .rd_resp_data(q_rd_data), .rd_resp_rdy(q_rd_rdy),
        .wr_resp_val(q_wr_val), .wr_resp_id(q_wr_id), .wr_resp_rdy(q_wr_rdy),
        .out_val(q_out_val), .out_is_wr(q_out_is_wr), .out_id(q_out_id), .out_data(q_out_data),
        .out_rdy(q_out_rdy), .order_err(q_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: contents of the output register and arbitration history.
    bit          m_val, m_w, m_last;
    bit [IW-1:0] m_id;
    bit [DW-1:0] m_d;
    bit          p_rv, p_wv;
    bit [IW-1:0] p_rid, p_wid;
    bit [DW-1:0] p_rd;
    bit          oq[$];
    int          nr, nw;

    task automatic model_load(input bit le, input bit gr, input bit gw);
        if (le) begin
            m_val = gr || gw;
            if (gw) begin
                m_w = 1'b1; m_id = p_wid; m_d = '0;
            end else if (gr) begin
                m_w = 1'b0; m_id = p_rid; m_d = p_rd;
            end
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic w,
                           input logic [IW-1:0] id, input logic [DW-1:0] d);
        chk({tag, "_val"}, 32'(v), 32'(m_val));
        if (m_val) begin
            chk({tag, "_is_wr"}, 32'(w), 32'(m_w));
            chk({tag, "_id"}, 32'(id), 32'(m_id));
            chk({tag, "_data"}, 32'(d), 32'(m_d));
        end
    endtask

    typedef struct {
        logic          rv;
        logic [IW-1:0] rid;
        logic [DW-1:0] rdata;
        logic          wv;
        logic [IW-1:0] wid;
        logic          ordy;
        logic          e_rrdy;
        logic          e_wrdy;
        logic          e_val;
        logic          e_wr;
        logic [IW-1:0] e_id;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t tbl[11];

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        bit le, gr, gw, exp_irdy, ri, wi;

        r_rd_issue = 0; r_wr_issue = 0; r_rd_val = 0; r_wr_val = 0;
        r_rd_id = '0; r_wr_id = '0; r_rd_data = '0; r_out_rdy = 1;
        q_rd_issue = 0; q_wr_issue = 0; q_rd_val = 0; q_wr_val = 0;
        q_rd_id = '0; q_wr_id = '0; q_rd_data = '0; q_out_rdy = 1;
        rst_n = 1'b0;
        tick();
        tick();

        // Reset state
        #2;
        chk("rst_issue_rdy_rr", 32'(r_issue_rdy), 0);
        chk("rst_issue_rdy_io", 32'(q_issue_rdy), 0);
        chk("rst_out_val", 32'(r_out_val), 0);
        chk("rst_out_is_wr", 32'(r_out_is_wr), 0);
        chk("rst_out_id", 32'(r_out_id), 0);
        chk("rst_out_data", 32'(r_out_data), 0);
        chk("rst_order_err", 32'(q_err), 0);
        rst_n = 1'b1;
        tick();
        #2;
        chk("rr_issue_rdy_tied", 32'(r_issue_rdy), 1);
        chk("io_issue_rdy_empty", 32'(q_issue_rdy), 1);
        tick();

        // Round-robin vector table (last_wr starts 0 so a write wins the first contention)
        tbl[0]  = '{1, 4'd3, 16'hA1A1, 1, 4'd5, 1,  0, 1,  1, 1, 4'd5, 16'h0000};
        tbl[1]  = '{1, 4'd3, 16'hA1A1, 1, 4'd5, 1,  1, 0,  1, 0, 4'd3, 16'hA1A1};
        tbl[2]  = '{1, 4'd3, 16'hC3C3, 1, 4'd5, 1,  0, 1,  1, 1, 4'd5, 16'h0000};
        tbl[3]  = '{1, 4'd3, 16'hC3C3, 0, 4'd0, 0,  0, 0,  1, 1, 4'd5, 16'h0000};
        tbl[4]  = '{1, 4'd3, 16'hC3C3, 0, 4'd0, 1,  1, 0,  1, 0, 4'd3, 16'hC3C3};
        tbl[5]  = '{0, 4'd0, 16'h0000, 1, 4'd9, 0,  0, 0,  1, 0, 4'd3, 16'hC3C3};
        tbl[6]  = '{0, 4'd0, 16'h0000, 1, 4'd9, 1,  0, 1,  1, 1, 4'd9, 16'h0000};
        tbl[7]  = '{0, 4'd0, 16'h0000, 0, 4'd0, 1,  0, 0,  0, 0, 4'd0, 16'h0000};
        tbl[8]  = '{1, 4'd2, 16'h0033, 1, 4'd4, 1,  1, 0,  1, 0, 4'd2, 16'h0033};
        tbl[9]  = '{1, 4'd6, 16'h0066, 1, 4'd4, 1,  0, 1,  1, 1, 4'd4, 16'h0000};
        tbl[10] = '{1, 4'd6, 16'h0066, 0, 4'd0, 1,  1, 0,  1, 0, 4'd6, 16'h0066};

        for (int i = 0; i < 11; i++) begin
            r_rd_val = tbl[i].rv; r_rd_id = tbl[i].rid; r_rd_data = tbl[i].rdata;
            r_wr_val = tbl[i].wv; r_wr_id = tbl[i].wid; r_out_rdy = tbl[i].ordy;
            #2;
            chk($sformatf("tbl%0d_rd_rdy", i), 32'(r_rd_rdy), 32'(tbl[i].e_rrdy));
            chk($sformatf("tbl%0d_wr_rdy", i), 32'(r_wr_rdy), 32'(tbl[i].e_wrdy));
            tick();
            chk($sformatf("tbl%0d_out_val", i), 32'(r_out_val), 32'(tbl[i].e_val));
            if (tbl[i].e_val) begin
                chk($sformatf("tbl%0d_is_wr", i), 32'(r_out_is_wr), 32'(tbl[i].e_wr));
                chk($sformatf("tbl%0d_id", i), 32'(r_out_id), 32'(tbl[i].e_id));
                chk($sformatf("tbl%0d_data", i), 32'(r_out_data), 32'(tbl[i].e_data));
            end
        end

        // Backpressure: output held while out_rdy=0, second read waits
        r_rd_val = 0; r_wr_val = 0; r_out_rdy = 1;
        tick();
        r_rd_val = 1; r_rd_id = 4'd1; r_rd_data = 16'hA5A5; r_out_rdy = 0;
        #2;
        chk("hold_load_rdy", 32'(r_rd_rdy), 1);
        tick();
        chk("hold_out_val", 32'(r_out_val), 1);
        chk("hold_out_data", 32'(r_out_data), 32'h0000A5A5);
        r_rd_id = 4'd2; r_rd_data = 16'h5A5A;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("hold%0d_rd_rdy", i), 32'(r_rd_rdy), 0);
            tick();
            chk($sformatf("hold%0d_id", i), 32'(r_out_id), 1);
            chk($sformatf("hold%0d_data", i), 32'(r_out_data), 32'h0000A5A5);
        end
        r_out_rdy = 1;
        #2;
        chk("hold_release_rdy", 32'(r_rd_rdy), 1);
        tick();
        chk("hold_next_data", 32'(r_out_data), 32'h00005A5A);
        chk("hold_next_val", 32'(r_out_val), 1);
        r_rd_val = 0;
        tick();

        // Randomized round-robin traffic
        m_val = 0; m_w = 0; m_last = 0; m_id = '0; m_d = '0;
        p_rv = 0; p_wv = 0; p_rid = '0; p_wid = '0; p_rd = '0;
        for (int c = 0; c < 300; c++) begin
            if (!p_rv && ($urandom % 2 == 0)) begin
                p_rv = 1; p_rid = IW'($urandom); p_rd = DW'($urandom);
            end
            if (!p_wv && ($urandom % 3 == 0)) begin
                p_wv = 1; p_wid = IW'($urandom);
            end
            r_out_rdy = ($urandom % 4 != 0);
            r_rd_val = p_rv; r_rd_id = p_rid; r_rd_data = p_rd;
            r_wr_val = p_wv; r_wr_id = p_wid;
            #2;
            le = !m_val || r_out_rdy;
            gr = 0; gw = 0;
            if (le) begin
                if (p_rv && p_wv) begin
                    gw = !m_last; gr = m_last;
                end else begin
                    gr = p_rv; gw = p_wv;
                end
            end
            chk("rr_rand_rd_rdy", 32'(r_rd_rdy), 32'(gr));
            chk("rr_rand_wr_rdy", 32'(r_wr_rdy), 32'(gw));
            model_load(le, gr, gw);
            if (gr || gw) m_last = gw;
            if (gr) p_rv = 0;
            if (gw) p_wv = 0;
            tick();
            chk_out("rr_rand", r_out_val, r_out_is_wr, r_out_id, r_out_data);
        end
        r_rd_val = 0; r_wr_val = 0; r_out_rdy = 1;
        chk("rr_no_err", 32'(r_err), 0);

        // In-order: write response with empty FIFO
        do_reset();
        q_wr_val = 1; q_wr_id = 4'd3;
        #2;
        chk("io_empty_wr_rdy", 32'(q_wr_rdy), 0);
        tick();
        chk("io_empty_err", 32'(q_err), 1);
        chk("io_empty_out_val", 32'(q_out_val), 0);
        q_wr_val = 0;

        // In-order: issue R+W then R; write response arrives first and must wait
        do_reset();
        q_rd_issue = 1; q_wr_issue = 1;
        tick();
        q_wr_issue = 0;
        tick();
        q_rd_issue = 0;
        q_wr_val = 1; q_wr_id = 4'd5;
        #2;
        chk("io_wr_stall", 32'(q_wr_rdy), 0);
        tick();
        chk("io_stall_out_val", 32'(q_out_val), 0);
        q_rd_val = 1; q_rd_id = 4'd3; q_rd_data = 16'h1111;
        #2;
        chk("io_r1_rdy", 32'(q_rd_rdy), 1);
        chk("io_w_still_stall", 32'(q_wr_rdy), 0);
        tick();
        chk("io_r1_is_wr", 32'(q_out_is_wr), 0);
        chk("io_r1_id", 32'(q_out_id), 3);
        q_rd_val = 0;
        #2;
        chk("io_w_rdy", 32'(q_wr_rdy), 1);
        tick();
        chk("io_w_is_wr", 32'(q_out_is_wr), 1);
        chk("io_w_id", 32'(q_out_id), 5);
        chk("io_w_data", 32'(q_out_data), 0);
        q_wr_val = 0; q_rd_val = 1; q_rd_id = 4'd4; q_rd_data = 16'h2222;
        #2;
        chk("io_r2_rdy", 32'(q_rd_rdy), 1);
        tick();
        chk("io_r2_is_wr", 32'(q_out_is_wr), 0);
        chk("io_r2_data", 32'(q_out_data), 32'h00002222);
        q_rd_val = 0;
        tick();
        chk("io_after_issue_rdy", 32'(q_issue_rdy), 1);
        chk("io_after_err", 32'(q_err), 0);

        // In-order: fill to 3 of 4, blocked issue flags and drops, pop frees space
        q_rd_issue = 1; q_wr_issue = 1;
        tick();
        q_wr_issue = 0;
        tick();
        q_rd_issue = 0;
        #2;
        chk("io_full_issue_rdy", 32'(q_issue_rdy), 0);
        q_wr_issue = 1;
        tick();
        q_wr_issue = 0;
        chk("io_overflow_err", 32'(q_err), 1);
        q_rd_val = 1; q_rd_id = 4'd1; q_rd_data = 16'h0101;
        #2;
        chk("io_pop_rd_rdy", 32'(q_rd_rdy), 1);
        tick();
        q_rd_val = 0;
        #2;
        chk("io_pop_frees", 32'(q_issue_rdy), 1);
        q_wr_val = 1; q_wr_id = 4'd2;
        #1;
        chk("io_drain_w", 32'(q_wr_rdy), 1);
        tick();
        q_wr_val = 0; q_rd_val = 1; q_rd_id = 4'd3; q_rd_data = 16'h0303;
        #2;
        chk("io_drain_r", 32'(q_rd_rdy), 1);
        tick();
        q_rd_val = 0; q_wr_val = 1; q_wr_id = 4'd9;
        #2;
        chk("io_dropped_entry", 32'(q_wr_rdy), 0);
        tick();
        q_wr_val = 0;

        // Randomized in-order traffic
        do_reset();
        m_val = 0; m_w = 0; m_id = '0; m_d = '0;
        p_rv = 0; p_wv = 0; nr = 0; nw = 0;
        oq.delete();
        for (int c = 0; c < 400; c++) begin
            exp_irdy = (4 - oq.size()) >= 2;
            ri = 0; wi = 0;
            if (exp_irdy) begin
                ri = ($urandom % 3 == 0);
                wi = ($urandom % 3 == 0);
            end
            if (!p_rv && nr > 0 && ($urandom % 2 == 0)) begin
                p_rv = 1; p_rid = IW'($urandom); p_rd = DW'($urandom); nr--;
            end
            if (!p_wv && nw > 0 && ($urandom % 2 == 0)) begin
                p_wv = 1; p_wid = IW'($urandom); nw--;
            end
            q_out_rdy = ($urandom % 4 != 0);
            q_rd_issue = ri; q_wr_issue = wi;
            q_rd_val = p_rv; q_rd_id = p_rid; q_rd_data = p_rd;
            q_wr_val = p_wv; q_wr_id = p_wid;
            #2;
            chk("io_rand_issue_rdy", 32'(q_issue_rdy), 32'(exp_irdy));
            le = !m_val || q_out_rdy;
            gr = 0; gw = 0;
            if (le && oq.size() > 0) begin
                gr = (oq[0] == 1'b0) && p_rv;
                gw = (oq[0] == 1'b1) && p_wv;
            end
            chk("io_rand_rd_rdy", 32'(q_rd_rdy), 32'(gr));
            chk("io_rand_wr_rdy", 32'(q_wr_rdy), 32'(gw));
            if (gr || gw) void'(oq.pop_front());
            if (ri) begin oq.push_back(1'b0); nr++; end
            if (wi) begin oq.push_back(1'b1); nw++; end
            model_load(le, gr, gw);
            if (gr) p_rv = 0;
            if (gw) p_wv = 0;
            tick();
            chk_out("io_rand", q_out_val, q_out_is_wr, q_out_id, q_out_data);
        end
        chk("io_rand_no_err", 32'(q_err), 0);
        q_rd_issue = 0; q_wr_issue = 0; q_rd_val = 0; q_wr_val = 0; q_out_rdy = 1;

        // Reset mid-transfer: output occupied, FIFO holding 2 entries, RR history = write
        do_reset();
        q_rd_issue = 1; q_wr_issue = 1;
        tick();
        q_wr_issue = 0;
        tick();
        q_rd_issue = 0;
        q_out_rdy = 0; q_rd_val = 1; q_rd_id = 4'd7; q_rd_data = 16'h7777;
        r_wr_val = 1; r_wr_id = 4'd8; r_out_rdy = 1;
        tick();
        q_rd_val = 0; r_wr_val = 0;
        chk("mid_out_val", 32'(q_out_val), 1);
        rst_n = 1'b0;
        q_rd_val = 1; q_rd_id = 4'd6;
        #2;
        chk("mid_rst_issue_rdy", 32'(q_issue_rdy), 0);
        chk("mid_rst_rd_rdy", 32'(q_rd_rdy), 0);
        tick();
        chk("mid_rst_out_val", 32'(q_out_val), 0);
        chk("mid_rst_out_id", 32'(q_out_id), 0);
        chk("mid_rst_out_data", 32'(q_out_data), 0);
        q_rd_val = 0;
        rst_n = 1'b1;
        q_out_rdy = 1;
        r_rd_val = 1; r_rd_id = 4'd1; r_rd_data = 16'h0F0F;
        r_wr_val = 1; r_wr_id = 4'd2;
        q_wr_val = 1; q_wr_id = 4'd4;
        #2;
        chk("post_rst_issue_rdy", 32'(q_issue_rdy), 1);
        chk("post_rst_fifo_empty", 32'(q_wr_rdy), 0);
        chk("post_rst_wr_first", 32'(r_wr_rdy), 1);
        chk("post_rst_rd_loses", 32'(r_rd_rdy), 0);
        tick();
        chk("post_rst_out_is_wr", 32'(r_out_is_wr), 1);
        chk("post_rst_out_id", 32'(r_out_id), 2);
        r_rd_val = 0; r_wr_val = 0; q_wr_val = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noc_axi4_resp_sched.md
Name: noc_axi4_resp_sched

Overview:
- Schedules the read-response and write-response streams returned by the AXI read/write engines onto the single serializer input of the NoC-AXI4 bridge.
- Arbitrates round-robin by default. With RDWR_INORDER=1, responses leave in the order their requests were issued, tracked by a read/write order FIFO.
- Has a one-entry registered output stage, so the serializer sees registered valid, id, data and type.

Parameters:
- ID_WIDTH, `AXI4_ID_WIDTH: response ID width.
- DATA_WIDTH, `AXI4_DATA_WIDTH: read response data width.
- RDWR_INORDER, 0: 0 = round-robin; 1 = strict issue order.
- ORDER_DEPTH_LOG2, 2: log2 of order FIFO depth. Used only when RDWR_INORDER=1.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rd_issue_val  in  1  read request accepted by read engine this cycle (pushes R into order FIFO)
- wr_issue_val  in  1  write request accepted by write engine this cycle (pushes W into order FIFO)
- issue_rdy  out  1  order FIFO has >=2 free entries; tied 1 when RDWR_INORDER=0
- rd_resp_val  in  1  read response valid
- rd_resp_id  in  ID_WIDTH  read response ID
- rd_resp_data  in  DATA_WIDTH  read response data
- rd_resp_rdy  out  1  read response accepted
- wr_resp_val  in  1  write response valid
- wr_resp_id  in  ID_WIDTH  write response ID
- wr_resp_rdy  out  1  write response accepted
- out_val  out  1  scheduled response valid
- out_is_wr  out  1  1 = write ack, 0 = read data
- out_id  out  ID_WIDTH  response ID
- out_data  out  DATA_WIDTH  read data; zero for write acks
- out_rdy  in  1  serializer ready
- order_err  out  1  sticky: a pop was attempted on an empty order FIFO, or a push on a full one

Behaviour:
- Output register
  - load_en = !out_val || out_rdy.
  - A winner is selected only when load_en=1. The winner's rdy is asserted combinationally in that same cycle, and out_* load at the next edge.
  - Latency from input val to out_val is 1 cycle. Sustained throughput is 1 response per cycle.
  - out_* hold stable while out_val && !out_rdy.
  - Loser rdy=0. Input val/data must stay stable until rdy (AXI-style).
- Round-robin mode (RDWR_INORDER=0)
  - Only one valid: grant it.
  - Both valid: grant the type not granted last (last_wr register, reset 0, so a write wins first on contention).
  - last_wr updates only on an actual grant.
- In-order mode (RDWR_INORDER=1)
  - Order FIFO is 2^ORDER_DEPTH_LOG2 x 1 bit, with rd/wr pointers of ORDER_DEPTH_LOG2+1 bits that wrap naturally.
  - Push: rd_issue_val pushes 0; wr_issue_val pushes 1. Both in the same cycle push 0 then 1 (two entries).
  - issue_rdy = free_count >= 2. Issuing while issue_rdy=0 sets order_err and drops the push.
  - Grant: only the response type equal to the FIFO head, and only when that response is valid. The other type stalls even if valid. Head pops on grant.
  - Same-cycle push and pop are allowed; count = count + pushes - pop.
  - FIFO empty: no grant (both rdy=0). A response valid while the FIFO is empty sets order_err, and the response stays stalled.
- order_err is sticky until reset.
- Reset (rst_n=0 at a clock edge, any time, including mid-transfer):
  - out_val=0, out_is_wr=0, out_id=0, out_data=0.
  - FIFO pointers 0 (empty), last_wr=0, order_err=0.
  - rd_resp_rdy=wr_resp_rdy=0 while rst_n=0; issue_rdy=0 while rst_n=0.
  - Responses pending at reset are discarded. Upstream is reset together with this block.

Test Plan:
- RR, rd and wr valid continuously, out_rdy=1, ids rd=3, wr=5 -> out sequence W5,R3,W5,R3..., one per cycle from cycle 1; out_data=0 on W entries.
- RR, rd_resp_val with data=0xA5.. and out_rdy=0 for 4 cycles -> out_val=1 from cycle 1; out_id/out_data held; rd_resp_rdy=1 only on the load cycle; second response not accepted until out_rdy=1.
- In-order, issue R,W,R (W+R in the same cycle), then write response arrives before read -> write stalls (wr_resp_rdy=0) until R emitted; final order R,W,R; FIFO empty after.
- In-order depth 4, issue 3 entries -> issue_rdy=0; one pop -> issue_rdy=1; push while issue_rdy=0 -> order_err=1 and the entry is dropped.
- In-order, wr_resp_val with FIFO empty -> no grant, order_err=1, wr_resp_rdy=0.
- Assert rst_n=0 with out_val=1 and 2 FIFO entries -> next cycle out_val=0, issue_rdy=0; after release FIFO empty, issue_rdy=1, first contended grant is write.
